// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_tx serial transmitter.
// Optional parity bit is enabled by defining PISO_TX_PARITY_EN.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_e;

`ifdef PISO_TX_PARITY_EN
    localparam int FRAME_EXTRA = 1;
`else
    localparam int FRAME_EXTRA = 0;
`endif

    // Bits needed to count 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r == 0) ? 1 : r;
    endfunction

    // Serial cycles per word: data bits plus the optional parity bit.
    function automatic int frame_len(input int width);
        return width + FRAME_EXTRA;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Loadable shift register; presents the next bit to send on bit_o.
module piso_shift_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             bit_o
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Next contents: a fresh word wins over a shift; zeros fill the vacated end.
    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = din_i;
        end else if (shift_i) begin
            if (MSB_FIRST) sr_d = {sr_q[WIDTH-2:0], 1'b0};
            else           sr_d = {1'b0, sr_q[WIDTH-1:1]};
        end
    end

    // Register update with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst_n) sr_q <= '0;
        else        sr_q <= sr_d;
    end

    assign bit_o = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready load handshake.
// Define PISO_TX_PARITY_EN to append an even-parity bit to every frame.
import piso_pkg::*;

module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done
);

    localparam int               CNT_W    = clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_bit;
    logic             accept;
    logic             sr_shift;
    logic             sr_bit;

`ifdef PISO_TX_PARITY_EN
    logic parity_q, parity_d;
`endif

    piso_shift_reg #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_reg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (accept),
        .shift_i (sr_shift),
        .din_i   (din),
        .bit_o   (sr_bit)
    );

    // Handshake and outputs decoded from registered state only.
    always_comb begin
`ifdef PISO_TX_PARITY_EN
        last_bit = (state_q == PAR);
`else
        last_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);
`endif
        load_ready = (state_q == IDLE) || last_bit;
        accept     = load_valid && load_ready;
        sout_valid = (state_q != IDLE);
        busy       = (state_q != IDLE);
        done       = last_bit;
        sout       = 1'b0;
        case (state_q)
            SHIFT:   sout = sr_bit;
`ifdef PISO_TX_PARITY_EN
            PAR:     sout = parity_q;
`endif
            default: sout = 1'b0;
        endcase
    end

    // Next-state, counter and shift control.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_shift = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
`ifdef PISO_TX_PARITY_EN
                    state_d = PAR;
`else
                    state_d = accept ? SHIFT : IDLE;
`endif
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    sr_shift = 1'b1;
                end
            end
            PAR: begin
                cnt_d   = '0;
                state_d = accept ? SHIFT : IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

`ifdef PISO_TX_PARITY_EN
    // Even parity of the word captured at accept time.
    always_comb begin
        parity_d = accept ? ^din : parity_q;
    end
`endif

    // State registers; reset drops any partial frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
`ifdef PISO_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef PISO_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: MSB-first and LSB-first instances driven in parallel,
// checked every cycle against a per-instance queue of expected serial bits.
module tb_piso_tx;

    localparam int W = 8;
`ifdef PISO_TX_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk;
    logic         rst_n;
    logic [W-1:0] din;
    logic         load_valid;
    logic         m_ready, m_sout, m_valid, m_busy, m_done;
    logic         l_ready, l_sout, l_valid, l_busy, l_done;

    int tests_run;
    int tests_failed;

    // Expected serial bits still to come, one entry per valid cycle.
    bit qm[$];
    bit ql[$];

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (m_ready),
        .sout       (m_sout),
        .sout_valid (m_valid),
        .busy       (m_busy),
        .done       (m_done)
    );

    piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .load_valid (load_valid),
        .load_ready (l_ready),
        .sout       (l_sout),
        .sout_valid (l_valid),
        .busy       (l_busy),
        .done       (l_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: apply inputs, check outputs at the falling edge, then
    // advance the reference model across the rising edge.
    task automatic step(input logic lv, input logic [W-1:0] d, input logic rn);
        bit acc;
        bit exp_active;
        load_valid = lv;
        din        = d;
        rst_n      = rn;
        @(negedge clk);
        exp_active = (qm.size() > 0);
        chk("msb_sout",  m_sout,  exp_active ? qm[0] : 1'b0);
        chk("msb_valid", m_valid, exp_active);
        chk("msb_busy",  m_busy,  exp_active);
        chk("msb_done",  m_done,  qm.size() == 1);
        chk("msb_ready", m_ready, qm.size() <= 1);
        chk("lsb_sout",  l_sout,  exp_active ? ql[0] : 1'b0);
        chk("lsb_valid", l_valid, exp_active);
        chk("lsb_busy",  l_busy,  exp_active);
        chk("lsb_done",  l_done,  ql.size() == 1);
        chk("lsb_ready", l_ready, ql.size() <= 1);
        acc = rn && lv && (qm.size() <= 1);
        @(posedge clk);
        if (!rn) begin
            qm.delete();
            ql.delete();
        end else begin
            if (qm.size() > 0) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
            end
            if (acc) begin
                for (int i = 0; i < W; i++) begin
                    qm.push_back(d[W-1-i]);
                    ql.push_back(d[i]);
                end
`ifdef PISO_TX_PARITY_EN
                qm.push_back(^d);
                ql.push_back(^d);
`endif
                $display("[TB] accept din=%h at %0t", d, $time);
            end
        end
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        load_valid   = 1'b0;
        din          = '0;
        rst_n        = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Idle after reset, nothing offered.
        repeat (3) step(1'b0, 8'h00, 1'b1);

        // Single word A5.
        step(1'b1, 8'hA5, 1'b1);
        repeat (FL + 1) step(1'b0, 8'h00, 1'b1);

        // Word 01 with an ignored mid-frame offer of FF.
        step(1'b1, 8'h01, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'hFF, 1'b1);
        repeat (FL) step(1'b0, 8'h00, 1'b1);

        // Back-to-back 0F then F0 with no gap.
        step(1'b1, 8'h0F, 1'b1);
        repeat (FL - 1) step(1'b0, 8'hF0, 1'b1);
        step(1'b1, 8'hF0, 1'b1);
        repeat (FL + 1) step(1'b0, 8'h00, 1'b1);

        // Reset after the third bit of C3, then a clean 81.
        step(1'b1, 8'hC3, 1'b1);
        repeat (3) step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h81, 1'b1);
        repeat (FL + 1) step(1'b0, 8'h00, 1'b1);

        // Parity-sensitive words (odd and even weight).
        step(1'b1, 8'h07, 1'b1);
        repeat (FL - 1) step(1'b0, 8'h00, 1'b1);
        step(1'b1, 8'h03, 1'b1);
        repeat (FL + 1) step(1'b0, 8'h00, 1'b1);

        // Random traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 3) != 0), 8'($urandom),
                 1'($urandom_range(0, 59) != 0));
        end
        repeat (FL + 1) step(1'b0, 8'h00, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
